cg_iteration_sequencer: RTL

- Top-level FSM that sequences one or more conjugate-gradient iterations on the complex ALU datapath.
- Datapath units it drives: r·r dot product, A·p matrix-vector product and p·Ap, alpha divider, x/r update, rsnew dot product, beta divider, p update.
- Releases each sub-unit's start/reset control in order and collects the finish flags.
- Latches rsold/rsnew, checks convergence against a tolerance, counts iterations, and guards every stage with a watchdog.

---
 rtl/cg_iteration_sequencer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/cg_iteration_sequencer.sv
// Control FSM that sequences conjugate-gradient iterations over the complex ALU
// datapath: releases each sub-unit in order, latches rsold/rsnew, tests convergence.
module cg_iteration_sequencer #(
  parameter int unsigned element_width   = 64,
  parameter logic [31:0] tolerance       = 32'h283424DC,
  parameter int unsigned max_iterations  = 1000,
  parameter int unsigned watchdog_cycles = 4096,
  parameter int unsigned cnt_width       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     go,
  input  logic                     abort,
  input  logic                     vXv1_finish,
  input  logic                     vXv2_finish,
  input  logic                     div1_finish,
  input  logic                     mul_add1_finish,
  input  logic                     mul_add2_finish,
  input  logic                     vXv3_finish,
  input  logic                     div2_finish,
  input  logic                     mul_add3_finish,
  input  logic [element_width-1:0] vXv1_result,
  input  logic [element_width-1:0] vXv3_result,
  output logic                     reset_vXv1,
  output logic                     reset_mXv1,
  output logic                     start_mul_add,
  output logic                     start_vXv3,
  output logic                     start_div2,
  output logic                     mul_add3_start,
  output logic [element_width-1:0] rold,
  output logic [element_width-1:0] rnew,
  output logic                     busy,
  output logic                     done,
  output logic                     converged,
  output logic                     timeout_err,
  output logic [cnt_width-1:0]     iteration_count
);

  localparam int unsigned              WD_W      = $clog2(watchdog_cycles + 1);
  localparam logic [WD_W-1:0]          WD_LAST   = WD_W'(watchdog_cycles - 1);
  localparam logic [element_width-1:0] TOL       = element_width'(tolerance);
  localparam logic [cnt_width-1:0]     CNT_LIMIT = cnt_width'(max_iterations);

  typedef enum logic [3:0] {
    S_IDLE, S_AP, S_ALPHA, S_UPDATE, S_RSNEW, S_BETA, S_PUPDATE, S_NEXT, S_DONE, S_ERR
  } state_t;

  state_t               state;
  logic                 f1, f2, f3, f4;
  logic [WD_W-1:0]      wd_cnt;
  logic                 ap_f1, ap_f2, ap_exit, upd_f3, upd_f4;
  logic                 wd_expired, rs_conv;
  logic                 stage_wait, stage_exit;
  logic [cnt_width-1:0] cnt_inc;

  // Sticky finish flags including a finish arriving this cycle
  assign ap_f1      = f1 | vXv1_finish;
  assign ap_f2      = f2 | vXv2_finish;
  assign upd_f3     = f3 | mul_add1_finish;
  assign upd_f4     = f4 | mul_add2_finish;
  assign ap_exit    = ap_f2 && (ap_f1 || (iteration_count != '0));
  assign wd_expired = (wd_cnt == WD_LAST);
  assign rs_conv    = (vXv3_result <= TOL);
  assign cnt_inc    = (iteration_count == '1) ? iteration_count
                                              : iteration_count + cnt_width'(1);

  // Which states are watchdog-guarded waits, and their exit condition
  always_comb begin
    stage_wait = 1'b1;
    stage_exit = 1'b0;
    case (state)
      S_AP:      stage_exit = ap_exit;
      S_ALPHA:   stage_exit = div1_finish;
      S_UPDATE:  stage_exit = upd_f3 && upd_f4;
      S_RSNEW:   stage_exit = vXv3_finish;
      S_BETA:    stage_exit = div2_finish;
      S_PUPDATE: stage_exit = mul_add3_finish;
      default:   stage_wait = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset || abort) begin
      state          <= S_IDLE;
      reset_vXv1     <= 1'b1;
      reset_mXv1     <= 1'b1;
      start_mul_add  <= 1'b0;
      start_vXv3     <= 1'b0;
      start_div2     <= 1'b0;
      mul_add3_start <= 1'b0;
      rold           <= '0;
      rnew           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      converged      <= 1'b0;
      timeout_err    <= 1'b0;
      {f1, f2, f3, f4} <= 4'b0000;
      wd_cnt         <= '0;
      // abort keeps the iteration count visible
      if (!reset) iteration_count <= '0;
    end else begin
      start_div2     <= 1'b0;
      mul_add3_start <= 1'b0;
      if (stage_wait) wd_cnt <= stage_exit ? '0 : wd_cnt + WD_W'(1);

      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (go) begin
            state           <= S_AP;
            iteration_count <= '0;
            {f1, f2, f3, f4} <= 4'b0000;
            wd_cnt          <= '0;
            reset_vXv1      <= 1'b0;
            reset_mXv1      <= 1'b0;
            busy            <= 1'b1;
            done            <= 1'b0;
            converged       <= 1'b0;
            timeout_err     <= 1'b0;
          end
        end
        S_AP: begin
          f1 <= ap_f1;
          f2 <= ap_f2;
          if (vXv1_finish && (iteration_count == '0)) rold <= vXv1_result;
          if (ap_exit) state <= S_ALPHA;
        end
        S_ALPHA: begin
          if (stage_exit) begin
            state         <= S_UPDATE;
            start_mul_add <= 1'b1;
          end
        end
        S_UPDATE: begin
          f3 <= upd_f3;
          f4 <= upd_f4;
          if (stage_exit) begin
            state         <= S_RSNEW;
            start_mul_add <= 1'b0;
            start_vXv3    <= 1'b1;
          end
        end
        S_RSNEW: begin
          if (stage_exit) begin
            rnew       <= vXv3_result;
            start_vXv3 <= 1'b0;
            if (rs_conv) begin
              state      <= S_DONE;
              busy       <= 1'b0;
              done       <= 1'b1;
              converged  <= 1'b1;
              reset_vXv1 <= 1'b1;
              reset_mXv1 <= 1'b1;
            end else begin
              state      <= S_BETA;
              start_div2 <= 1'b1;
            end
          end
        end
        S_BETA: begin
          if (stage_exit) begin
            state          <= S_PUPDATE;
            mul_add3_start <= 1'b1;
          end
        end
        S_PUPDATE: begin
          if (stage_exit) begin
            state      <= S_NEXT;
            reset_vXv1 <= 1'b1;
            reset_mXv1 <= 1'b1;
          end
        end
        S_NEXT: begin
          iteration_count  <= cnt_inc;
          rold             <= rnew;
          {f1, f2, f3, f4} <= 4'b0000;
          if (cnt_inc == CNT_LIMIT) begin
            state     <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            converged <= 1'b0;
          end else begin
            // later iterations reuse rold, so vXv1 stays held
            state      <= S_AP;
            reset_mXv1 <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Watchdog expiry overrides whatever the wait state decided
      if (stage_wait && !stage_exit && wd_expired) begin
        state            <= S_ERR;
        timeout_err      <= 1'b1;
        busy             <= 1'b0;
        reset_vXv1       <= 1'b1;
        reset_mXv1       <= 1'b1;
        start_mul_add    <= 1'b0;
        start_vXv3       <= 1'b0;
        start_div2       <= 1'b0;
        mul_add3_start   <= 1'b0;
        {f1, f2, f3, f4} <= 4'b0000;
        wd_cnt           <= '0;
      end
    end
  end

endmodule
